tpu_stage_sequencer: RTL

Sequences one TPU run after the host writes the start bit in the start/done register.
- Issues a start pulse to each enabled stage (matmul, norm, activation, pool), in that fixed order.
- Waits for each stage's done pulse, counts cycles and detects hung stages.
- Raises a sticky done flag that the APB register block returns as bit 31 of the start/done register.
- Sits between the APB register file and the compute stages.

---
 rtl/tpu_seq_pkg.sv | 27 ++
 rtl/tpu_stage_sequencer_if.sv | 30 +++
 rtl/tpu_next_stage_sel.sv | 25 ++
 rtl/tpu_stage_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared definitions for the TPU stage sequencer: FSM encoding,
// stage index constants and default sizing.
package tpu_seq_pkg;

  // state     | meaning
  // ST_IDLE   | waiting for a start request, flags hold their last value
  // ST_LAUNCH | one-cycle start pulse to the selected stage
  // ST_WAIT   | waiting for the selected stage's done pulse, timeout running
  // ST_FINISH | all enabled stages complete, raise done flag
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  localparam int STG_MATMUL = 0;
  localparam int STG_NORM   = 1;
  localparam int STG_ACT    = 2;
  localparam int STG_POOL   = 3;

  localparam int NUM_STAGES_DEFAULT     = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 65535;
  localparam int CNT_WIDTH_DEFAULT      = 32;
  localparam int TMO_WIDTH              = 16;

endpackage

// File: rtl/tpu_stage_sequencer_if.sv
// Host/stage-facing signal bundle of the stage sequencer. The master side
// is the register block plus the stages, the slave side is the sequencer.
interface tpu_stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  start_req;
  logic                  clr_done;
  logic [NUM_STAGES-1:0] enables;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_start;
  logic                  busy;
  logic                  done_flag;
  logic                  timeout_err;
  logic [IDX_W-1:0]      cur_stage;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    output start_req, clr_done, enables, stage_done,
    input  stage_start, busy, done_flag, timeout_err, cur_stage, cycle_count
  );

  modport slave (
    input  start_req, clr_done, enables, stage_done,
    output stage_start, busy, done_flag, timeout_err, cur_stage, cycle_count
  );

endinterface

// File: rtl/tpu_next_stage_sel.sv
// Priority finder: lowest set bit of i_mask strictly above i_cur.
// i_cur is signed so that -1 selects the first enabled stage.
module tpu_next_stage_sel #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_STAGES-1:0] i_mask,
  input  logic signed [IDX_W:0] i_cur,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_vld
);

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_idx = IDX_W'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpu_stage_sequencer.sv
// Runs the enabled compute stages in fixed order, one at a time, with a
// per-stage hang timeout and a saturating run cycle counter.
module tpu_stage_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int NUM_STAGES     = NUM_STAGES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  tpu_stage_sequencer_if.slave  bus
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  seq_state_t            r_state;
  logic [NUM_STAGES-1:0] r_en_q;
  logic [IDX_W-1:0]      r_cur_stage;
  logic [NUM_STAGES-1:0] r_stage_start;
  logic                  r_busy;
  logic                  r_done_flag;
  logic                  r_timeout_err;
  logic [TMO_WIDTH-1:0]  r_tmo;
  logic [CNT_WIDTH-1:0]  r_cycle_count;

  logic [NUM_STAGES-1:0] w_sel_mask;
  logic signed [IDX_W:0] w_sel_cur;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_vld;

  // In IDLE the live enables pick the first stage (search from -1);
  // afterwards the latched mask picks the successor of the current stage.
  always_comb begin
    w_sel_mask = r_en_q;
    w_sel_cur  = $signed({1'b0, r_cur_stage});
    if (r_state == ST_IDLE) begin
      w_sel_mask = bus.enables;
      w_sel_cur  = '1;
    end
  end

  tpu_next_stage_sel #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_next_sel (
    .i_mask (w_sel_mask),
    .i_cur  (w_sel_cur),
    .o_idx  (w_sel_idx),
    .o_vld  (w_sel_vld)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_en_q        <= '0;
      r_cur_stage   <= '0;
      r_stage_start <= '0;
      r_busy        <= 1'b0;
      r_done_flag   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tmo         <= '0;
      r_cycle_count <= '0;
    end else begin
      r_stage_start <= '0;
      if ((r_state != ST_IDLE) && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start_req) begin
            r_en_q        <= bus.enables;
            r_done_flag   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cycle_count <= '0;
            r_busy        <= 1'b1;
            if (w_sel_vld) begin
              r_cur_stage   <= w_sel_idx;
              r_stage_start <= NUM_STAGES'(1) << w_sel_idx;
              r_state       <= ST_LAUNCH;
            end else begin
              r_state <= ST_FINISH;
            end
          end else if (bus.clr_done) begin
            r_done_flag   <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done on the limit cycle takes priority over the abort.
          if (bus.stage_done[r_cur_stage]) begin
            if (w_sel_vld) begin
              r_cur_stage   <= w_sel_idx;
              r_stage_start <= NUM_STAGES'(1) << w_sel_idx;
              r_state       <= ST_LAUNCH;
            end else begin
              r_state <= ST_FINISH;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_done_flag   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_WIDTH'(1);
          end
        end
        ST_FINISH: begin
          r_done_flag <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stage_start = r_stage_start;
  assign bus.busy        = r_busy;
  assign bus.done_flag   = r_done_flag;
  assign bus.timeout_err = r_timeout_err;
  assign bus.cur_stage   = r_cur_stage;
  assign bus.cycle_count = r_cycle_count;

endmodule
